// File: rtl/bus_master.sv
// bus_master: initiator for the shared tri-state system bus.
// Takes one read/write request at a time over valid/ready. It runs a
// SETUP / strobe / RESP bus cycle and returns read data or a no-responder error.
module bus_master #(
  parameter int unsigned READ_WAIT = 1,
  parameter int unsigned ADDR_W    = 24,
  parameter int unsigned DATA_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] address,
  inout  wire  [DATA_W-1:0] data,
  output logic              loadEnable,
  output logic              outputEnable,
  input  logic              anyMatch
);

  // Read-wait counter counts down from READ_WAIT-1 to 0.
  localparam int unsigned    CNT_W    = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_WAIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_WRITE = 3'd2,
    ST_READ  = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_write;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_drive;
  logic [ADDR_W-1:0]   r_address;
  logic                r_load_en;
  logic                r_out_en;
  logic                r_req_ready;
  logic                r_resp_valid;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_err;

  state_t              w_state_nxt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic                w_write_nxt;
  logic [DATA_W-1:0]   w_wdata_nxt;
  logic                w_drive_nxt;
  logic [ADDR_W-1:0]   w_address_nxt;
  logic                w_load_en_nxt;
  logic                w_out_en_nxt;
  logic                w_req_ready_nxt;
  logic                w_resp_valid_nxt;
  logic [DATA_W-1:0]   w_rdata_nxt;
  logic                w_err_nxt;

  // State and registered bus/handshake outputs; reset aborts any cycle in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_write      <= 1'b0;
      r_wdata      <= '0;
      r_drive      <= 1'b0;
      r_address    <= '0;
      r_load_en    <= 1'b0;
      r_out_en     <= 1'b0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_rdata      <= '0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_write      <= w_write_nxt;
      r_wdata      <= w_wdata_nxt;
      r_drive      <= w_drive_nxt;
      r_address    <= w_address_nxt;
      r_load_en    <= w_load_en_nxt;
      r_out_en     <= w_out_en_nxt;
      r_req_ready  <= w_req_ready_nxt;
      r_resp_valid <= w_resp_valid_nxt;
      r_rdata      <= w_rdata_nxt;
      r_err        <= w_err_nxt;
    end
  end

  // Next state plus the output values for the state being entered.
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_write_nxt      = r_write;
    w_wdata_nxt      = r_wdata;
    w_drive_nxt      = 1'b0;
    w_address_nxt    = r_address;
    w_load_en_nxt    = 1'b0;
    w_out_en_nxt     = 1'b0;
    w_req_ready_nxt  = 1'b0;
    w_resp_valid_nxt = 1'b0;
    w_rdata_nxt      = r_rdata;
    w_err_nxt        = r_err;

    case (r_state)
      ST_IDLE: begin
        w_req_ready_nxt = 1'b1;
        if (req_valid) begin
          w_state_nxt     = ST_SETUP;
          w_req_ready_nxt = 1'b0;
          w_write_nxt     = req_write;
          w_wdata_nxt     = req_wdata;
          w_address_nxt   = req_addr;
          w_drive_nxt     = req_write;
          w_rdata_nxt     = '0;
          w_err_nxt       = 1'b0;
        end
      end

      ST_SETUP: begin
        if (!anyMatch) begin
          w_state_nxt      = ST_RESP;
          w_resp_valid_nxt = 1'b1;
          w_err_nxt        = 1'b1;
          w_rdata_nxt      = '0;
        end else if (r_write) begin
          w_state_nxt   = ST_WRITE;
          w_load_en_nxt = 1'b1;
          w_drive_nxt   = 1'b1;
        end else begin
          w_state_nxt  = ST_READ;
          w_out_en_nxt = 1'b1;
          w_cnt_nxt    = CNT_LOAD;
        end
      end

      ST_WRITE: begin
        w_state_nxt      = ST_RESP;
        w_resp_valid_nxt = 1'b1;
      end

      ST_READ: begin
        if (r_cnt == '0) begin
          w_state_nxt      = ST_RESP;
          w_resp_valid_nxt = 1'b1;
          w_rdata_nxt      = data;
        end else begin
          w_cnt_nxt    = r_cnt - CNT_W'(1);
          w_out_en_nxt = 1'b1;
        end
      end

      ST_RESP: begin
        if (resp_ready) begin
          w_state_nxt     = ST_IDLE;
          w_req_ready_nxt = 1'b1;
        end else begin
          w_resp_valid_nxt = 1'b1;
        end
      end

      default: begin
        w_state_nxt     = ST_IDLE;
        w_req_ready_nxt = 1'b1;
      end
    endcase
  end

  // Write data goes on the bus only in SETUP/WRITE of a write cycle.
  assign data         = r_drive ? r_wdata : {DATA_W{1'bz}};

  assign req_ready    = r_req_ready;
  assign resp_valid   = r_resp_valid;
  assign resp_rdata   = r_rdata;
  assign resp_err     = r_err;
  assign address      = r_address;
  assign loadEnable   = r_load_en;
  assign outputEnable = r_out_en;

endmodule

// File: tb/tb_bus_master.sv
// tb_bus_master: directed vector table plus hand sequences for bus_master.
module tb_bus_master;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;
  localparam logic [15:0] P = 16'h5A5A;  // value the bench puts on a released bus

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // DUT 1: READ_WAIT = 1
  logic        rst1, rv1, wr1, am1, rr1, tde1;
  logic [23:0] ad1;
  logic [15:0] wd1, tdv1;
  logic        rqr1, rsv1, err1, le1, oe1;
  logic [15:0] rd1;
  logic [23:0] addr1;
  wire  [15:0] data1;
  assign data1 = tde1 ? tdv1 : 16'hzzzz;

  bus_master #(.READ_WAIT(1), .ADDR_W(24), .DATA_W(16)) u_dut1 (
    .clk(clk), .reset(rst1), .req_valid(rv1), .req_ready(rqr1), .req_write(wr1),
    .req_addr(ad1), .req_wdata(wd1), .resp_valid(rsv1), .resp_ready(rr1),
    .resp_rdata(rd1), .resp_err(err1), .address(addr1), .data(data1),
    .loadEnable(le1), .outputEnable(oe1), .anyMatch(am1)
  );

  // DUT 3: READ_WAIT = 3
  logic        rst3, rv3, wr3, am3, rr3, tde3;
  logic [23:0] ad3;
  logic [15:0] wd3, tdv3;
  logic        rqr3, rsv3, err3, le3, oe3;
  logic [15:0] rd3;
  logic [23:0] addr3;
  wire  [15:0] data3;
  assign data3 = tde3 ? tdv3 : 16'hzzzz;

  bus_master #(.READ_WAIT(3), .ADDR_W(24), .DATA_W(16)) u_dut3 (
    .clk(clk), .reset(rst3), .req_valid(rv3), .req_ready(rqr3), .req_write(wr3),
    .req_addr(ad3), .req_wdata(wd3), .resp_valid(rsv3), .resp_ready(rr3),
    .resp_rdata(rd3), .resp_err(err3), .address(addr3), .data(data3),
    .loadEnable(le3), .outputEnable(oe3), .anyMatch(am3)
  );

  typedef struct {
    logic        rv, wr;
    logic [23:0] ad;
    logic [15:0] wd;
    logic        am, rr, de;
    logic [15:0] dv;
    logic        e_rqr, e_rsv;
    logic [23:0] e_ad;
    logic        e_le, e_oe, e_dc;
    logic [15:0] e_d, e_rd;
    logic        e_err;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
  endtask

  task automatic cyc3(input logic rv, input logic rr, input logic de, input logic [15:0] dv);
    @(negedge clk);
    rv3 = rv; rr3 = rr; tde3 = de; tdv3 = dv;
    #1;
  endtask

  // READ_WAIT=3 read: the value on the bus in the last READ cycle is returned.
  task automatic read3(input int tag, input logic [15:0] d0, input logic [15:0] d1,
                       input logic [15:0] d2);
    cyc3(H, L, H, P);
    chk("r3_idle_ready", tag, 32'(rqr3), 32'(H));
    cyc3(L, L, H, P);
    chk("r3_setup_oe", tag, 32'(oe3), 32'(L));
    chk("r3_setup_data", tag, 32'(data3), 32'(P));
    cyc3(L, L, H, d0);
    chk("r3_read1_oe", tag, 32'(oe3), 32'(H));
    chk("r3_read1_data", tag, 32'(data3), 32'(d0));
    cyc3(L, L, H, d1);
    chk("r3_read2_oe", tag, 32'(oe3), 32'(H));
    chk("r3_read2_data", tag, 32'(data3), 32'(d1));
    cyc3(L, L, H, d2);
    chk("r3_read3_oe", tag, 32'(oe3), 32'(H));
    chk("r3_read3_valid", tag, 32'(rsv3), 32'(L));
    cyc3(L, H, H, P);
    chk("r3_resp_valid", tag, 32'(rsv3), 32'(H));
    chk("r3_resp_oe", tag, 32'(oe3), 32'(L));
    chk("r3_resp_rdata", tag, 32'(rd3), 32'(d2));
    chk("r3_resp_err", tag, 32'(err3), 32'(L));
    cyc3(L, L, H, P);
    chk("r3_back_idle", tag, 32'(rqr3), 32'(H));
    chk("r3_back_valid", tag, 32'(rsv3), 32'(L));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t v;
    rst1 = H; rv1 = L; wr1 = L; ad1 = '0; wd1 = '0; am1 = L; rr1 = L; tde1 = H; tdv1 = P;
    rst3 = H; rv3 = L; wr3 = L; ad3 = 24'h03F010; wd3 = 16'hFFFF; am3 = H; rr3 = L;
    tde3 = H; tdv3 = P;

    // Vectors: {rv,wr,ad,wd,am,rr,de,dv, e_rqr,e_rsv,e_ad,e_le,e_oe,e_dc,e_d,e_rd,e_err}
    // write A5A5 -> 03F010
    vq.push_back('{H,H,24'h03F010,16'hA5A5,H,L,H,P,        H,L,24'h000000,L,L,H,P,16'h0,L});
    vq.push_back('{L,L,24'h0,16'h0,H,L,L,16'h0,            L,L,24'h03F010,L,L,H,16'hA5A5,16'h0,L});
    vq.push_back('{L,L,24'h0,16'h0,H,L,L,16'h0,            L,L,24'h03F010,H,L,H,16'hA5A5,16'h0,L});
    vq.push_back('{L,L,24'h0,16'h0,H,H,H,P,                L,H,24'h03F010,L,L,H,P,16'h0,L});
    // read 03F010, target returns 1234; response held one cycle
    vq.push_back('{H,L,24'h03F010,16'hFFFF,H,L,H,P,        H,L,24'h03F010,L,L,H,P,16'h0,L});
    vq.push_back('{L,L,24'h0,16'h0,H,L,H,P,                L,L,24'h03F010,L,L,H,P,16'h0,L});
    vq.push_back('{L,L,24'h0,16'h0,H,L,H,16'h1234,         L,L,24'h03F010,L,H,H,16'h1234,16'h0,L});
    vq.push_back('{L,L,24'h0,16'h0,H,L,H,P,                L,H,24'h03F010,L,L,H,P,16'h1234,L});
    vq.push_back('{L,L,24'h0,16'h0,H,H,H,P,                L,H,24'h03F010,L,L,H,P,16'h1234,L});
    // read 100000 with no responder
    vq.push_back('{H,L,24'h100000,16'h0,L,L,H,P,           H,L,24'h03F010,L,L,H,P,16'h0,L});
    vq.push_back('{L,L,24'h0,16'h0,L,L,H,P,                L,L,24'h100000,L,L,H,P,16'h0,L});
    vq.push_back('{L,L,24'h0,16'h0,L,H,H,P,                L,H,24'h100000,L,L,H,P,16'h0,H});
    // write 0F0F -> 000ABC, then a read of 000DEF waits through 4 stalled RESP cycles
    vq.push_back('{H,H,24'h000ABC,16'h0F0F,H,L,H,P,        H,L,24'h100000,L,L,H,P,16'h0,L});
    vq.push_back('{H,L,24'h000DEF,16'h0,H,L,L,16'h0,       L,L,24'h000ABC,L,L,H,16'h0F0F,16'h0,L});
    vq.push_back('{H,L,24'h000DEF,16'h0,H,L,L,16'h0,       L,L,24'h000ABC,H,L,H,16'h0F0F,16'h0,L});
    for (int k = 0; k < 4; k++)
      vq.push_back('{H,L,24'h000DEF,16'h0,H,L,H,P,         L,H,24'h000ABC,L,L,H,P,16'h0,L});
    vq.push_back('{H,L,24'h000DEF,16'h0,H,H,H,P,           L,H,24'h000ABC,L,L,H,P,16'h0,L});
    vq.push_back('{H,L,24'h000DEF,16'h0,H,L,H,P,           H,L,24'h000ABC,L,L,H,P,16'h0,L});
    vq.push_back('{L,L,24'h0,16'h0,H,L,H,P,                L,L,24'h000DEF,L,L,H,P,16'h0,L});
    vq.push_back('{L,L,24'h0,16'h0,H,L,H,16'hBEEF,         L,L,24'h000DEF,L,H,H,16'hBEEF,16'h0,L});
    vq.push_back('{L,L,24'h0,16'h0,H,H,H,P,                L,H,24'h000DEF,L,L,H,P,16'hBEEF,L});
    vq.push_back('{L,L,24'h0,16'h0,L,L,H,P,                H,L,24'h000DEF,L,L,H,P,16'h0,L});

    // Reset state of both instances
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req_ready", 0, 32'(rqr1), 32'(H));
    chk("rst_resp_valid", 0, 32'(rsv1), 32'(L));
    chk("rst_rdata", 0, 32'(rd1), 32'h0);
    chk("rst_err", 0, 32'(err1), 32'(L));
    chk("rst_address", 0, 32'(addr1), 32'h0);
    chk("rst_le", 0, 32'(le1), 32'(L));
    chk("rst_oe", 0, 32'(oe1), 32'(L));
    chk("rst_data", 0, 32'(data1), 32'(P));
    chk("rst3_req_ready", 0, 32'(rqr3), 32'(H));
    rst1 = L; rst3 = L;

    // Table-driven run on the READ_WAIT=1 instance
    for (int i = 0; i < vq.size(); i++) begin
      v = vq[i];
      @(negedge clk);
      rv1 = v.rv; wr1 = v.wr; ad1 = v.ad; wd1 = v.wd; am1 = v.am; rr1 = v.rr;
      tde1 = v.de; tdv1 = v.dv;
      #1;
      chk("req_ready", i, 32'(rqr1), 32'(v.e_rqr));
      chk("resp_valid", i, 32'(rsv1), 32'(v.e_rsv));
      chk("address", i, 32'(addr1), 32'(v.e_ad));
      chk("loadEnable", i, 32'(le1), 32'(v.e_le));
      chk("outputEnable", i, 32'(oe1), 32'(v.e_oe));
      if (v.e_dc) chk("data", i, 32'(data1), 32'(v.e_d));
      if (v.e_rsv) begin
        chk("resp_rdata", i, 32'(rd1), 32'(v.e_rd));
        chk("resp_err", i, 32'(err1), 32'(v.e_err));
      end
    end

    // READ_WAIT=3: three outputEnable cycles, last one sampled; twice for counter reload
    read3(1, 16'h1111, 16'h2222, 16'h3333);
    read3(2, 16'h4444, 16'h5555, 16'h6666);

    // Reset during READ aborts the cycle with no later response
    cyc3(H, L, H, P);
    cyc3(L, L, H, P);
    @(negedge clk);
    rv3 = L; rr3 = L; tde3 = H; tdv3 = 16'h7777; rst3 = H;
    #1;
    chk("rst_mid_oe_before", 0, 32'(oe3), 32'(H));
    cyc3(L, H, H, P);
    rst3 = L;
    chk("rst_mid_oe", 0, 32'(oe3), 32'(L));
    chk("rst_mid_valid", 0, 32'(rsv3), 32'(L));
    chk("rst_mid_ready", 0, 32'(rqr3), 32'(H));
    chk("rst_mid_data", 0, 32'(data3), 32'(P));
    chk("rst_mid_rdata", 0, 32'(rd3), 32'h0);
    for (int k = 0; k < 6; k++) begin
      cyc3(L, H, H, P);
      chk("rst_no_stale_valid", k, 32'(rsv3), 32'(L));
      chk("rst_no_stale_oe", k, 32'(oe3), 32'(L));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
